// File: rtl/vx_amo_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vx_amo_unit: read-modify-write atomic memory operation sequencer      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module vx_amo_unit #(
    parameter int ADDRW = 32,
    parameter int TAGW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [31:0]      req_data,
    input  logic [TAGW-1:0]  req_tag,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_rw,
    output logic [ADDRW-1:0] mem_req_addr,
    output logic [31:0]      mem_req_data,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    output logic             mem_rsp_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAGW-1:0]  rsp_tag
);

    localparam logic [4:0] AMO_ADD  = 5'h00;
    localparam logic [4:0] AMO_SWAP = 5'h01;
    localparam logic [4:0] AMO_XOR  = 5'h04;
    localparam logic [4:0] AMO_OR   = 5'h08;
    localparam logic [4:0] AMO_AND  = 5'h0C;
    localparam logic [4:0] AMO_MIN  = 5'h10;
    localparam logic [4:0] AMO_MAX  = 5'h14;
    localparam logic [4:0] AMO_MINU = 5'h18;
    localparam logic [4:0] AMO_MAXU = 5'h1C;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_EXEC    = 3'd3,
        S_WR_REQ  = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [ADDRW-1:0]   addr_q, addr_d;
    logic [31:0]        operand_q, operand_d;
    logic [TAGW-1:0]    tag_q, tag_d;
    logic [31:0]        old_q, old_d;
    logic [31:0]        new_q, new_d;

    logic               w_signed, w_is_max, w_pick_operand, w_supported;
    logic [32:0]        w_old33, w_opd33, w_lhs, w_rhs;
    logic [31:0]        w_result;

    // One signed 33-bit comparator serves all four min/max ops; operands are
    // swapped for MAX so that a tie always keeps the old value.
    always_comb begin
        w_signed       = (op_q == AMO_MIN) || (op_q == AMO_MAX);
        w_is_max       = (op_q == AMO_MAX) || (op_q == AMO_MAXU);
        w_old33        = {w_signed & old_q[31], old_q};
        w_opd33        = {w_signed & operand_q[31], operand_q};
        w_lhs          = w_is_max ? w_old33 : w_opd33;
        w_rhs          = w_is_max ? w_opd33 : w_old33;
        w_pick_operand = $signed(w_lhs) < $signed(w_rhs);
        w_supported    = 1'b1;
        w_result       = old_q;
        case (op_q)
            AMO_ADD:  w_result = old_q + operand_q;
            AMO_SWAP: w_result = operand_q;
            AMO_XOR:  w_result = old_q ^ operand_q;
            AMO_OR:   w_result = old_q | operand_q;
            AMO_AND:  w_result = old_q & operand_q;
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU:
                      w_result = w_pick_operand ? operand_q : old_q;
            default:  w_supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        tag_d     = tag_q;
        old_d     = old_q;
        new_d     = new_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    addr_d    = req_addr;
                    operand_d = req_data;
                    tag_d     = req_tag;
                    state_d   = S_RD_REQ;
                end
            end
            S_RD_REQ:  if (mem_req_ready) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    old_d   = mem_rsp_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                new_d   = w_result;
                state_d = w_supported ? S_WR_REQ : S_RSP;
            end
            S_WR_REQ:  if (mem_req_ready) state_d = S_RSP;
            S_RSP:     if (rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            tag_q     <= '0;
            old_q     <= '0;
            new_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            tag_q     <= tag_d;
            old_q     <= old_d;
            new_q     <= new_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign mem_req_rw    = (state_q == S_WR_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_data  = (state_q == S_WR_REQ) ? new_q : 32'd0;
    assign mem_rsp_ready = (state_q == S_RD_WAIT);
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_data      = old_q;
    assign rsp_tag       = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_amo_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_vx_amo_unit: directed bench with memory model and response queue   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vx_amo_unit;

    localparam int ADDRW = 32;
    localparam int TAGW  = 8;
    localparam logic [4:0] OP_ADD  = 5'h00, OP_SWAP = 5'h01, OP_XOR  = 5'h04,
                           OP_OR   = 5'h08, OP_AND  = 5'h0C, OP_MIN  = 5'h10,
                           OP_MAX  = 5'h14, OP_MINU = 5'h18, OP_MAXU = 5'h1C,
                           OP_LR   = 5'h02;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_op = '0;
    logic [ADDRW-1:0] req_addr = '0;
    logic [31:0]      req_data = '0;
    logic [TAGW-1:0]  req_tag = '0;
    logic             mem_req_valid;
    logic             mem_req_ready = 1'b1;
    logic             mem_req_rw;
    logic [ADDRW-1:0] mem_req_addr;
    logic [31:0]      mem_req_data;
    logic             mem_rsp_valid = 1'b0;
    logic [31:0]      mem_rsp_data = '0;
    logic             mem_rsp_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_data;
    logic [TAGW-1:0]  rsp_tag;

    initial forever #5 clk = ~clk;

    vx_amo_unit #(.ADDRW(ADDRW), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
    );

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [31:0]     old;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [logic [31:0]];
    int          tests = 0, fails = 0;
    int          rd_cnt = 0, wr_cnt = 0, rsp_cyc = 0, hold_err = 0;
    logic [31:0] last_rd_addr = '0;
    bit          rd_pending = 0, hold_rsp = 0, spurious = 0;
    int          stall_rd = 0, stall_wr = 0, stall_rsp = 0;

    bit          p_mv = 0, p_rw = 0, p_rv = 0;
    logic [31:0] p_ad = '0, p_dt = '0, p_rd = '0;
    logic [7:0]  p_rt = '0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] amo_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SWAP: return b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_MIN:  return ($signed(b) < $signed(a)) ? b : a;
            OP_MAX:  return ($signed(a) < $signed(b)) ? b : a;
            OP_MINU: return (b < a) ? b : a;
            OP_MAXU: return (a < b) ? b : a;
            default: return a;
        endcase
    endfunction

    function automatic bit op_writes(input logic [4:0] op);
        return op inside {OP_ADD, OP_SWAP, OP_XOR, OP_OR, OP_AND, OP_MIN, OP_MAX, OP_MINU, OP_MAXU};
    endfunction

    // Memory model and hold-stability monitor, sampled on the active edge.
    always @(posedge clk) begin
        if (reset) begin
            p_mv = 0; p_rv = 0; rd_pending = 0;
        end else begin
            if (p_mv && !(mem_req_valid && mem_req_rw == p_rw && mem_req_addr == p_ad && mem_req_data == p_dt))
                hold_err++;
            if (p_rv && !(rsp_valid && rsp_data == p_rd && rsp_tag == p_rt))
                hold_err++;
            p_mv = mem_req_valid && !mem_req_ready;
            p_rw = mem_req_rw; p_ad = mem_req_addr; p_dt = mem_req_data;
            p_rv = rsp_valid && !rsp_ready;
            p_rd = rsp_data; p_rt = rsp_tag;
            if (rsp_valid) rsp_cyc++;
            if (mem_rsp_valid && mem_rsp_ready) rd_pending = 0;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_rw) begin
                    wr_cnt++;
                    mem[mem_req_addr] = mem_req_data;
                end else begin
                    rd_cnt++;
                    last_rd_addr = mem_req_addr;
                    rd_pending = 1;
                end
            end
        end
    end

    // Handshake responders drive on the falling edge.
    always @(negedge clk) begin
        if (mem_req_valid && !mem_req_rw && stall_rd > 0) begin
            mem_req_ready = 0; stall_rd--;
        end else if (mem_req_valid && mem_req_rw && stall_wr > 0) begin
            mem_req_ready = 0; stall_wr--;
        end else begin
            mem_req_ready = 1;
        end
        if (rd_pending && mem_rsp_ready && !hold_rsp) begin
            mem_rsp_valid = 1; mem_rsp_data = mem[last_rd_addr];
        end else if (spurious && !mem_rsp_ready) begin
            mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
        end else begin
            mem_rsp_valid = 0; mem_rsp_data = '0;
        end
        if (rsp_valid && stall_rsp > 0) begin
            rsp_ready = 0; stall_rsp--;
        end else begin
            rsp_ready = 1;
        end
    end

    task automatic run_amo(input string name, input logic [4:0] op, input logic [31:0] addr,
                           input logic [31:0] b, input logic [7:0] tag,
                           output int wait_cyc, output int lat);
        exp_t        e;
        logic [31:0] old, exp_new;
        bit          exp_wr;
        int          rd0, wr0, k;
        old     = mem[addr];
        exp_wr  = op_writes(op);
        exp_new = exp_wr ? amo_model(op, old, b) : old;
        sb_q.push_back('{tag: tag, old: old});
        rd0 = rd_cnt; wr0 = wr_cnt;
        req_valid = 1; req_op = op; req_addr = addr; req_data = b; req_tag = tag;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 50) begin @(posedge clk); #1; wait_cyc++; end
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        e = sb_q.pop_front();
        check({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({name, "_rsp_data"}, rsp_data, e.old);
        check({name, "_rsp_tag"}, {24'd0, rsp_tag}, {24'd0, e.tag});
        k = 0;
        while (k < 50) begin
            @(posedge clk);
            if (rsp_valid && rsp_ready) break;
            k++;
        end
        #1;
        check({name, "_rsp_handshake"}, {31'd0, (k < 50)}, 32'd1);
        check({name, "_reads"}, rd_cnt - rd0, 32'd1);
        check({name, "_rd_addr"}, last_rd_addr, addr);
        check({name, "_writes"}, wr_cnt - wr0, {31'd0, exp_wr});
        check({name, "_mem"}, mem[addr], exp_new);
    endtask

    initial begin
        int w, l, rc0, wc0, k;
        logic [31:0] a;
        logic [4:0]  ops [0:4];
        ops[0] = OP_XOR; ops[1] = OP_OR; ops[2] = OP_AND; ops[3] = OP_MAXU; ops[4] = OP_ADD;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_tag", {24'd0, rsp_tag}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);

        mem[32'h100] = 32'd5;
        run_amo("add", OP_ADD, 32'h100, 32'd3, 8'h2A, w, l);
        check("add_latency", l, 32'd5);

        mem[32'h200] = 32'hFFFFFFFF;
        run_amo("min", OP_MIN, 32'h200, 32'd1, 8'h01, w, l);
        check("min_value", mem[32'h200], 32'hFFFFFFFF);
        mem[32'h200] = 32'hFFFFFFFF;
        run_amo("minu", OP_MINU, 32'h200, 32'd1, 8'h02, w, l);
        check("minu_value", mem[32'h200], 32'd1);
        check("b2b_accept_wait", w, 32'd0);

        mem[32'h300] = 32'd7;
        run_amo("max_tie", OP_MAX, 32'h300, 32'd7, 8'h03, w, l);

        mem[32'h400] = 32'h12345678;
        stall_rd = 3; stall_wr = 3; stall_rsp = 2; spurious = 1;
        hold_err = 0;
        run_amo("swap_stall", OP_SWAP, 32'h400, 32'hCAFEF00D, 8'h44, w, l);
        spurious = 0;
        check("swap_value", mem[32'h400], 32'hCAFEF00D);
        check("swap_latency", l, 32'd11);
        check("hold_stable", hold_err, 32'd0);

        mem[32'h500] = 32'd9;
        run_amo("unsupported", OP_LR, 32'h500, 32'd4, 8'h55, w, l);

        for (int i = 0; i < 5; i++) begin
            a = 32'h600 + 32'(i * 4);
            mem[a] = $urandom;
            run_amo("mixed", ops[i], a, $urandom, 8'(i + 8'h60), w, l);
        end

        // Abandon an AMO while it waits for read data.
        mem[32'h700] = 32'd11;
        hold_rsp = 1;
        rc0 = rd_cnt; wc0 = wr_cnt;
        req_valid = 1; req_op = OP_ADD; req_addr = 32'h700; req_data = 32'd1; req_tag = 8'h77;
        @(posedge clk); #1;
        req_valid = 0;
        k = 0;
        while (!mem_rsp_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("rdwait_reached", {31'd0, mem_rsp_ready}, 32'd1);
        rsp_cyc = 0;
        #1 reset = 1;
        #1;
        check("midrst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0; hold_rsp = 0;
        @(posedge clk); #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_tag_cleared", {24'd0, rsp_tag}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_reads", rd_cnt - rc0, 32'd1);
        check("midrst_no_write", wr_cnt - wc0, 32'd0);
        check("midrst_no_rsp", rsp_cyc, 32'd0);
        check("midrst_mem", mem[32'h700], 32'd11);

        mem[32'h800] = 32'h80000000;
        run_amo("after_rst_max", OP_MAX, 32'h800, 32'h7FFFFFFF, 8'h88, w, l);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
